// File: rtl/grn_mmio_master.sv
// CCI-P MMIO requester: queues local read/write commands, issues them one at a time
// on a c0 Rx-typed channel and returns read data (or a timeout) from the c2 Tx channel.
package grn_ccip_pkg;

  typedef struct packed {
    logic [15:0] address;
    logic [1:0]  length;
    logic        rsvd;
    logic [8:0]  tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMmioHdr hdr;
    logic [63:0]         data;
    logic                mmioRdValid;
    logic                mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;

  // Queued command; only the 8-byte-aligned part of the address is kept.
  typedef struct packed {
    logic        write;
    logic [14:0] addr_qw;
    logic [63:0] data;
  } t_mmio_cmd;

endpackage

module grn_mmio_master
  import grn_ccip_pkg::*;
#(
  parameter int unsigned CMD_DEPTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic           cmd_write,
  input  logic [17:0]    cmd_addr,
  input  logic [63:0]    cmd_data,
  output t_if_ccip_c0_Rx mmio_req,
  input  t_if_ccip_c2_Tx mmio_rsp,
  output logic           rsp_valid,
  output logic [63:0]    rsp_data,
  output logic           rsp_timeout,
  output logic [8:0]     rsp_tid,
  output logic           busy,
  output logic [15:0]    err_count
);

  localparam int unsigned PW     = $clog2(CMD_DEPTH);
  localparam int unsigned CW     = PW + 1;
  localparam int unsigned TW     = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned TID_W  = 9;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned ERR_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD
  } state_t;

  state_t              state_q, state_d;
  t_mmio_cmd           fifo_mem [CMD_DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q, count_d;
  logic [TID_W-1:0]    tid_q, tid_d;
  logic [TID_W-1:0]    cur_tid_q, cur_tid_d;
  logic [TW-1:0]       timer_q, timer_d;
  t_if_ccip_c0_Rx      req_d;
  logic                rsp_valid_d, rsp_timeout_d;
  logic [DATA_W-1:0]   rsp_data_d;
  logic [TID_W-1:0]    rsp_tid_d;
  logic [ERR_W-1:0]    err_d;
  logic                busy_d, cmd_ready_d;
  logic                push, pop, err_inc, rsp_hit;
  t_mmio_cmd           head, entry;
  logic                unused_addr_lsbs;

  assign push  = cmd_valid && cmd_ready;
  assign head  = fifo_mem[rd_ptr_q];
  assign entry = '{write: cmd_write, addr_qw: cmd_addr[17:3], data: cmd_data};
  assign unused_addr_lsbs = ^cmd_addr[2:0];

  // Command storage; contents need no reset since pointers/count gate every use.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tid_q       <= '0;
      cur_tid_q   <= '0;
      timer_q     <= '0;
      mmio_req    <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
      rsp_tid     <= '0;
      busy        <= 1'b0;
      cmd_ready   <= 1'b1;
      err_count   <= '0;
    end else begin
      state_q     <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q     <= count_d;
      tid_q       <= tid_d;
      cur_tid_q   <= cur_tid_d;
      timer_q     <= timer_d;
      mmio_req    <= req_d;
      rsp_valid   <= rsp_valid_d;
      rsp_data    <= rsp_data_d;
      rsp_timeout <= rsp_timeout_d;
      rsp_tid     <= rsp_tid_d;
      busy        <= busy_d;
      cmd_ready   <= cmd_ready_d;
      err_count   <= err_d;
    end
  end

  assign rsp_hit = mmio_rsp.mmioRdValid && (mmio_rsp.hdr.tid == cur_tid_q);

  // Next state plus the next value of every registered output.
  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    tid_d         = tid_q;
    cur_tid_d     = cur_tid_q;
    timer_d       = timer_q;
    req_d         = '0;
    rsp_valid_d   = 1'b0;
    rsp_data_d    = rsp_data;
    rsp_timeout_d = rsp_timeout;
    rsp_tid_d     = rsp_tid;
    err_inc       = 1'b0;

    unique case (state_q)
      IDLE: begin
        err_inc = mmio_rsp.mmioRdValid;
        if (count_q != '0) begin
          pop                 = 1'b1;
          req_d.hdr.address   = {head.addr_qw, 1'b0};
          req_d.hdr.length    = 2'b01;
          req_d.hdr.tid       = tid_q;
          req_d.data          = head.write ? head.data : '0;
          req_d.mmioWrValid   = head.write;
          req_d.mmioRdValid   = ~head.write;
          cur_tid_d           = tid_q;
          state_d             = ISSUE;
        end
      end
      ISSUE: begin
        err_inc = mmio_rsp.mmioRdValid;
        tid_d   = tid_q + TID_W'(1);
        timer_d = '0;
        state_d = mmio_req.mmioWrValid ? IDLE : WAIT_RD;
      end
      WAIT_RD: begin
        if (rsp_hit) begin
          rsp_valid_d   = 1'b1;
          rsp_data_d    = mmio_rsp.data;
          rsp_timeout_d = 1'b0;
          rsp_tid_d     = cur_tid_q;
          state_d       = IDLE;
        end else begin
          err_inc = mmio_rsp.mmioRdValid;
          // The last sampling cycle is T+TIMEOUT_CYCLES; a hit there wins above.
          if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            rsp_valid_d   = 1'b1;
            rsp_data_d    = '0;
            rsp_timeout_d = 1'b1;
            rsp_tid_d     = cur_tid_q;
            state_d       = IDLE;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    err_d = err_count;
    if (err_inc && (err_count != '1)) begin
      err_d = err_count + ERR_W'(1);
    end

    cmd_ready_d = (count_d != CW'(CMD_DEPTH));
    busy_d      = (count_d != '0) || (state_d != IDLE);
  end

endmodule

// File: tb/tb_grn_mmio_master.sv
// Bench for grn_mmio_master: directed scenarios with literal expectations plus a random
// phase, all outputs compared every cycle against a transaction-timing reference model.
module tb_grn_mmio_master;
  import grn_ccip_pkg::*;

  localparam int DEPTH = 4;
  localparam int TO    = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic           cmd_write = 1'b0;
  logic [17:0]    cmd_addr = '0;
  logic [63:0]    cmd_data = '0;
  t_if_ccip_c0_Rx mmio_req;
  t_if_ccip_c2_Tx mmio_rsp = '0;
  logic           rsp_valid;
  logic [63:0]    rsp_data;
  logic           rsp_timeout;
  logic [8:0]     rsp_tid;
  logic           busy;
  logic [15:0]    err_count;

  grn_mmio_master #(.CMD_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .mmio_req(mmio_req), .mmio_rsp(mmio_rsp),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .rsp_tid(rsp_tid), .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: commands queue up, each one occupies the engine for a fixed
  // span measured in absolute cycles (write: pop+1..pop+2, read: until answered/timed out).
  typedef struct packed {
    logic        w;
    logic [17:0] a;
    logic [63:0] d;
  } mcmd_t;

  mcmd_t          mq[$];
  bit             m_valid = 0;
  bit             op_act, op_read, op_done;
  int             op_t, op_free;
  logic [8:0]     op_tid, m_tid;
  logic           e_ready, e_busy, e_rv, e_rto;
  logic [63:0]    e_rdata;
  logic [8:0]     e_rtid;
  logic [15:0]    e_err;
  t_if_ccip_c0_Rx e_req;

  always @(posedge clk) begin
    int p, c;
    bit pulse, err_hit, in_win, idle_p;
    mcmd_t hd;
    p = cyc;
    cyc = cyc + 1;
    c = cyc;
    if (reset) begin
      mq.delete();
      op_act = 0; op_done = 0; op_read = 0; op_t = 0; op_free = 0; op_tid = '0;
      m_tid = '0; e_ready = 1; e_busy = 0; e_rv = 0; e_rto = 0; e_rdata = '0;
      e_rtid = '0; e_err = '0; e_req = '0;
      m_valid = 1;
    end else if (m_valid) begin
      pulse = 0;
      err_hit = 0;
      in_win = op_act && op_read && !op_done && (p >= op_t + 1) && (p <= op_t + TO);
      if (in_win) begin
        if (mmio_rsp.mmioRdValid && mmio_rsp.hdr.tid == op_tid) begin
          pulse = 1; e_rdata = mmio_rsp.data; e_rto = 0; op_done = 1; op_free = p + 1;
        end else begin
          if (mmio_rsp.mmioRdValid) err_hit = 1;
          if (p == op_t + TO) begin
            pulse = 1; e_rdata = '0; e_rto = 1; op_done = 1; op_free = p + 1;
          end
        end
      end else if (mmio_rsp.mmioRdValid) begin
        err_hit = 1;
      end
      idle_p = !op_act || (op_done && p >= op_free);
      if (idle_p && mq.size() > 0) begin
        hd = mq.pop_front();
        op_act = 1; op_read = !hd.w; op_t = p + 1; op_tid = m_tid; m_tid = m_tid + 9'd1;
        op_done = hd.w; op_free = op_t + 1;
        e_req = '0;
        e_req.hdr.address = {hd.a[17:3], 1'b0};
        e_req.hdr.length = 2'b01;
        e_req.hdr.tid = op_tid;
        e_req.data = hd.w ? hd.d : 64'd0;
        e_req.mmioWrValid = hd.w;
        e_req.mmioRdValid = !hd.w;
      end
      if (cmd_valid && e_ready) mq.push_back('{w: cmd_write, a: cmd_addr, d: cmd_data});
      e_ready = (mq.size() < DEPTH);
      e_busy = (mq.size() != 0) || !(!op_act || (op_done && c >= op_free));
      if (!(op_act && op_t == c)) e_req = '0;
      e_rv = pulse;
      if (pulse) e_rtid = op_tid;
      if (err_hit && e_err != 16'hFFFF) e_err = e_err + 16'd1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cmd_ready", 64'(cmd_ready), 64'(e_ready));
      chk("busy", 64'(busy), 64'(e_busy));
      chk("req_hdr", 64'(mmio_req.hdr), 64'(e_req.hdr));
      chk("req_data", mmio_req.data, e_req.data);
      chk("req_valids", 64'({mmio_req.mmioRdValid, mmio_req.mmioWrValid}),
          64'({e_req.mmioRdValid, e_req.mmioWrValid}));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
      chk("rsp_data", rsp_data, e_rdata);
      chk("rsp_timeout", 64'(rsp_timeout), 64'(e_rto));
      chk("rsp_tid", 64'(rsp_tid), 64'(e_rtid));
      chk("err_count", 64'(err_count), 64'(e_err));
    end
  end

  // Stimulus helpers; the optional auto-responder answers reads with random latency.
  bit          auto_rsp = 0;
  bit          pend = 0;
  int          pend_at = 0;
  logic [8:0]  pend_tid = '0;
  logic [63:0] pend_data = '0;

  task automatic step();
    @(posedge clk);
    #1;
    mmio_rsp = '0;
    if (auto_rsp) begin
      if (pend && cyc == pend_at) begin
        mmio_rsp.mmioRdValid = 1'b1;
        mmio_rsp.hdr.tid = pend_tid;
        mmio_rsp.data = pend_data;
        pend = 0;
      end else if ($urandom_range(0, 29) == 0) begin
        mmio_rsp.mmioRdValid = 1'b1;
        mmio_rsp.hdr.tid = 9'($urandom_range(0, 511));
        mmio_rsp.data = {$urandom, $urandom};
      end
      if (mmio_req.mmioRdValid && $urandom_range(0, 7) != 0) begin
        pend = 1;
        pend_at = cyc + $urandom_range(1, TO + 3);
        pend_tid = mmio_req.hdr.tid;
        pend_data = {$urandom, $urandom};
      end
    end
  endtask

  task automatic drive_rsp(input logic [8:0] tid, input logic [63:0] data);
    mmio_rsp.mmioRdValid = 1'b1;
    mmio_rsp.hdr.tid = tid;
    mmio_rsp.data = data;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic push(input logic w, input logic [17:0] a, input logic [63:0] d);
    int n = 0;
    while (!cmd_ready && n < 200) begin
      step();
      n++;
    end
    if (!cmd_ready) chk("push_wait_ready", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_data = d;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_issue(input bit want_read, output int t);
    bit found = 0;
    t = -1;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (want_read ? mmio_req.mmioRdValid : (mmio_req.mmioRdValid || mmio_req.mmioWrValid)) begin
        found = 1;
        t = cyc;
      end
    end
    if (!found) chk("issue_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, seen, iss[4], t2;
    logic [8:0] tid_seen;

    // Reset state
    do_reset();
    chk("reset_ready", 64'(cmd_ready), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_err", 64'(err_count), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);

    // Single write: one-cycle request, DW address 0x8, tid 0
    push(1'b1, 18'h00020, 64'h1234);
    chk("wr_busy_p1", 64'(busy), 64'd1);
    step();
    chk("wr_valid", 64'(mmio_req.mmioWrValid), 64'd1);
    chk("wr_addr", 64'(mmio_req.hdr.address), 64'h0008);
    chk("wr_len", 64'(mmio_req.hdr.length), 64'd1);
    chk("wr_tid", 64'(mmio_req.hdr.tid), 64'd0);
    chk("wr_data", mmio_req.data, 64'h1234);
    step();
    chk("wr_valid_drop", 64'(mmio_req.mmioWrValid), 64'd0);
    chk("wr_busy_drop", 64'(busy), 64'd0);
    chk("wr_no_rsp", 64'(rsp_valid), 64'd0);

    // Read answered 5 cycles after the request
    do_reset();
    push(1'b0, 18'h00008, 64'hDEAD);
    wait_issue(1'b1, t);
    chk("rd_addr", 64'(mmio_req.hdr.address), 64'h0002);
    chk("rd_data_zero", mmio_req.data, 64'd0);
    repeat (5) step();
    drive_rsp(9'd0, 64'hC000C9660D824272);
    step();
    chk("rd_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rd_rsp_data", rsp_data, 64'hC000C9660D824272);
    chk("rd_rsp_to", 64'(rsp_timeout), 64'd0);
    chk("rd_rsp_tid", 64'(rsp_tid), 64'd0);
    step();
    chk("rd_rsp_pulse", 64'(rsp_valid), 64'd0);
    chk("rd_rsp_hold", rsp_data, 64'hC000C9660D824272);

    // Timeout at T+17, then a late response counts as unexpected
    do_reset();
    push(1'b0, 18'h00100, 64'd0);
    wait_issue(1'b1, t);
    repeat (16) step();
    chk("to_not_yet", 64'(rsp_valid), 64'd0);
    step();
    chk("to_cycle", 64'(cyc - t), 64'd17);
    chk("to_valid", 64'(rsp_valid), 64'd1);
    chk("to_flag", 64'(rsp_timeout), 64'd1);
    chk("to_data", rsp_data, 64'd0);
    repeat (3) step();
    drive_rsp(9'd0, 64'h55);
    step();
    chk("late_err", 64'(err_count), 64'd1);

    // Wrong tid discarded, right tid accepted
    do_reset();
    repeat (3) push(1'b1, 18'h00040, 64'h1);
    push(1'b0, 18'h00048, 64'd0);
    wait_issue(1'b1, t);
    chk("tid3_issue", 64'(mmio_req.hdr.tid), 64'd3);
    step();
    drive_rsp(9'd5, 64'h55);
    step();
    drive_rsp(9'd3, 64'hAA);
    chk("tid5_err", 64'(err_count), 64'd1);
    step();
    chk("tid3_valid", 64'(rsp_valid), 64'd1);
    chk("tid3_data", rsp_data, 64'hAA);
    chk("tid3_tid", 64'(rsp_tid), 64'd3);

    // Match in the final sampling cycle beats the timeout
    do_reset();
    push(1'b0, 18'h00010, 64'd0);
    wait_issue(1'b1, t);
    repeat (16) step();
    drive_rsp(9'd0, 64'h77);
    step();
    chk("edge_valid", 64'(rsp_valid), 64'd1);
    chk("edge_to", 64'(rsp_timeout), 64'd0);
    chk("edge_data", rsp_data, 64'h77);

    // Stalled read with a full FIFO of writes behind it
    do_reset();
    push(1'b0, 18'h00018, 64'd0);
    wait_issue(1'b1, t);
    for (int i = 1; i <= DEPTH; i++) push(1'b1, 18'(i * 8), 64'(i));
    chk("full_ready", 64'(cmd_ready), 64'd0);
    seen = 0;
    while (cyc < t + 12) begin
      step();
      if (mmio_req.mmioWrValid) seen++;
    end
    chk("stall_no_write", 64'(seen), 64'd0);
    drive_rsp(9'd0, 64'h99);
    seen = 0;
    for (int i = 0; i < 40 && seen < DEPTH; i++) begin
      step();
      if (mmio_req.mmioWrValid) begin
        chk("rel_order", mmio_req.data, 64'(seen + 1));
        iss[seen] = cyc;
        seen++;
      end
    end
    chk("rel_count", 64'(seen), 64'(DEPTH));
    chk("rel_first", 64'(iss[0] - t), 64'd14);
    for (int i = 1; i < DEPTH; i++) chk("rel_spacing", 64'(iss[i] - iss[i-1]), 64'd2);

    // Reset while a read is pending
    do_reset();
    push(1'b0, 18'h00020, 64'd0);
    wait_issue(1'b1, t);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    seen = 0;
    repeat (20) begin
      step();
      if (rsp_valid) seen++;
    end
    chk("rst_no_rsp", 64'(seen), 64'd0);
    drive_rsp(9'd0, 64'h1);
    step();
    chk("rst_late_err", 64'(err_count), 64'd1);
    push(1'b1, 18'h00008, 64'h5);
    wait_issue(1'b0, t2);
    chk("rst_tid_restart", 64'(mmio_req.hdr.tid), 64'd0);

    // 513 issues: tid wraps 511 -> 0
    do_reset();
    for (int i = 0; i <= 512; i++) begin
      push(1'b1, 18'(i * 8), 64'(i));
      wait_issue(1'b0, t2);
      tid_seen = mmio_req.hdr.tid;
      if (i == 511) chk("tid_511", 64'(tid_seen), 64'd511);
      if (i == 512) chk("tid_wrap", 64'(tid_seen), 64'd0);
    end

    // Random traffic against the model
    do_reset();
    auto_rsp = 1;
    for (int i = 0; i < 3000; i++) begin
      step();
      reset     = ($urandom_range(0, 599) == 0);
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = 18'($urandom);
      cmd_data  = {$urandom, $urandom};
    end
    reset = 1'b0;
    cmd_valid = 1'b0;
    auto_rsp = 0;
    repeat (40) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/grn_mmio_master.md
Name: grn_mmio_master

Overview:
- MMIO initiator for the CCI-P MMIO protocol; the requester counterpart of the AFU CSR responder.
- Accepts queued read/write commands from a local sequencer (on-FPGA self-test or host model) and drives MMIO write/read requests on a c0 Rx-typed channel.
- Collects the matching c2 Tx read responses and reports them as data or timeout.
- Strictly one outstanding read; commands complete in order.

Parameters:
- CMD_DEPTH, 4, command FIFO entries (power of 2, ≥2).
- TIMEOUT_CYCLES, 256, cycles to wait for a read response before reporting a timeout (≥2).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept (= !full).
- cmd_write  in  1  1 = MMIO write, 0 = MMIO read.
- cmd_addr  in  18  byte address.
- cmd_data  in  64  write data; ignored for reads.
- mmio_req  out  t_if_ccip_c0_Rx  request channel to the CSR responder.
- mmio_rsp  in  t_if_ccip_c2_Tx  response channel from the CSR responder.
- rsp_valid  out  1  one-cycle pulse per completed read.
- rsp_data  out  64  read data; 0 on timeout.
- rsp_timeout  out  1  qualifies rsp_valid.
- rsp_tid  out  9  tid of the completed read.
- busy  out  1  FIFO non-empty or state ≠ IDLE.
- err_count  out  16  saturating count of unexpected responses.

Behaviour:
- Reset (clk, synchronous, active-high):
  - mmio_req all zero (mmioWrValid = mmioRdValid = 0); rsp_* = 0; err_count = 0; tid counter = 0; state IDLE.
  - FIFO flushed.
  - A read in flight is abandoned with no rsp_valid.
- Push: cmd_valid && cmd_ready stores {write, addr, data}. Push while full is impossible (cmd_ready = 0). Simultaneous push and pop is legal at any fill level.
- FSM states: IDLE, ISSUE, WAIT_RD.
- IDLE:
  - If the FIFO is non-empty, pop the head into the command register and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly one cycle, cycle T):
  - Assert mmioWrValid (write) or mmioRdValid (read) for this single cycle.
  - hdr.address = {cmd_addr[17:3], 1'b0}; 8 B access, so the DW address is always even.
  - hdr.length = 2'b01; hdr.tid = tid counter.
  - data = cmd_data for writes, 0 for reads.
  - Tid counter increments after every issue, wrapping 511→0.
  - Next state: write → IDLE; read → WAIT_RD with timer cleared.
  - Maximum throughput is one command per 2 cycles.
- WAIT_RD:
  - The timer increments each cycle. Sample mmio_rsp each cycle T+1..T+TIMEOUT_CYCLES.
  - mmioRdValid with hdr.tid == issued tid: the next cycle pulses rsp_valid=1, rsp_data=data, rsp_timeout=0, rsp_tid=tid; state → IDLE.
  - mmioRdValid with a different tid: err_count += 1 (saturate at 0xFFFF); response discarded; keep waiting; the timer is not reset.
  - No match by T+TIMEOUT_CYCLES: at T+TIMEOUT_CYCLES+1 pulse rsp_valid=1, rsp_timeout=1, rsp_data=0; state → IDLE.
  - A matching response in the final sampling cycle wins over the timeout.
- Unexpected responses: any mmioRdValid seen in IDLE or ISSUE, including late responses after a timeout, increments err_count.
- Ordering: a queued write behind a pending read is not issued until that read completes or times out.
- Output timing: rsp_* are registered. rsp_data, rsp_tid and rsp_timeout hold their values until the next rsp_valid; rsp_valid is high for exactly 1 cycle.

Test Plan:
- Write cmd {write=1, addr=0x00020, data=0x1234}:
  - mmio_req.mmioWrValid high for exactly 1 cycle with hdr.address=0x0008, length=1, tid=0, data=0x1234.
  - No rsp_valid; busy drops 2 cycles after the push.
- Read addr 0x00008; responder returns tid 0, data 0xC000C9660D824272, 5 cycles after the request:
  - rsp_valid 1 cycle later with that data, rsp_timeout=0, rsp_tid=0.
- TIMEOUT_CYCLES=16, read with no response:
  - rsp_valid at T+17 with rsp_timeout=1, rsp_data=0.
  - A response injected at T+20 makes err_count=1.
- Read with tid 3 outstanding; responder sends tid 5, then tid 3 with data 0xAA:
  - err_count=1, then rsp_valid with data 0xAA.
  - Separately, a matching response exactly at T+TIMEOUT_CYCLES gives rsp_timeout=0.
- Stall responder, push 1 read + CMD_DEPTH writes:
  - cmd_ready=0 once full; no write issues before the read completes.
  - Release: the writes issue in order, on every other cycle.
  - 512 issued commands wrap the tid from 511 to 0.
- Assert reset at T+3 of a pending read:
  - No rsp_valid, FIFO empty, busy=0, tid restarts at 0.
  - A late response after reset increments err_count to 1.
